// File: rtl/mesh_term_fifo_bank.sv
// rtl/mesh_term_fifo_bank.sv - bank of per-terminal input FIFOs feeding mesh_gnrtr terminals
//
// One independent circular-buffer FIFO per router terminal (NTRM = 2*ROWS+2*COLUMS).
// Ports (channel i occupies slice [i*W +: W] of every flattened vector):
//   clk, reset      clock, synchronous active-high reset
//   push, data_in   per-channel write strobe and packet
//   popin           router pop of the head entry
//   clr_ovf         clear all drop counters
//   data_out_i_in   head entry (first-word-fall-through, 0 when empty)
//   pndng_i_in      channel non-empty
//   full            count == fifo_depth
//   almost_full     count >= AF_LEVEL
//   count           occupancy
//   ovf_cnt         saturating count of dropped pushes
module mesh_term_fifo_bank #(
   parameter int ROWS       = 4,
   parameter int COLUMS     = 4,
   parameter int pckg_sz    = 40,
   parameter int fifo_depth = 4,
   parameter int AF_LEVEL   = 3,
   localparam int NTRM      = 2*ROWS + 2*COLUMS,
   localparam int CW        = $clog2(fifo_depth + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NTRM-1:0]         push,
   input  logic [NTRM*pckg_sz-1:0] data_in,
   input  logic [NTRM-1:0]         popin,
   input  logic                    clr_ovf,
   output logic [NTRM*pckg_sz-1:0] data_out_i_in,
   output logic [NTRM-1:0]         pndng_i_in,
   output logic [NTRM-1:0]         full,
   output logic [NTRM-1:0]         almost_full,
   output logic [NTRM*CW-1:0]      count,
   output logic [NTRM*8-1:0]       ovf_cnt
);

   localparam int PW = $clog2(fifo_depth);

   for (genvar i = 0; i < NTRM; i++) begin : g_ch
      logic [pckg_sz-1:0] mem [fifo_depth];
      logic [PW-1:0]      rd_ptr;
      logic [PW-1:0]      wr_ptr;
      logic [CW-1:0]      cnt;
      logic [7:0]         ovf;
      logic               is_full;
      logic               is_empty;
      logic               do_push;
      logic               do_pop;
      logic               drop;

      assign is_full  = (cnt == CW'(fifo_depth));
      assign is_empty = (cnt == '0);
      // A full FIFO still accepts a push when the router pops in the same cycle.
      assign do_push  = push[i] && (!is_full || popin[i]);
      // Pops on an empty FIFO are ignored, even when a push lands in that cycle.
      assign do_pop   = popin[i] && !is_empty;
      assign drop     = push[i] && is_full && !popin[i];

      always_ff @(posedge clk) begin
         if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            ovf    <= '0;
         end else begin
            if (do_push)
               wr_ptr <= (wr_ptr == PW'(fifo_depth - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
               rd_ptr <= (rd_ptr == PW'(fifo_depth - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
               2'b10:   cnt <= cnt + 1'b1;
               2'b01:   cnt <= cnt - 1'b1;
               default: cnt <= cnt;
            endcase
            // Clear has priority over a coincident drop.
            if (clr_ovf)
               ovf <= '0;
            else if (drop && ovf != 8'hff)
               ovf <= ovf + 1'b1;
         end
      end

      // Storage is not reset; the output is masked while the channel is empty.
      always_ff @(posedge clk) begin
         if (!reset && do_push)
            mem[wr_ptr] <= data_in[i*pckg_sz +: pckg_sz];
      end

      assign data_out_i_in[i*pckg_sz +: pckg_sz] = is_empty ? '0 : mem[rd_ptr];
      assign pndng_i_in[i]                       = !is_empty;
      assign full[i]                             = is_full;
      assign almost_full[i]                      = (cnt >= CW'(AF_LEVEL));
      assign count[i*CW +: CW]                   = cnt;
      assign ovf_cnt[i*8 +: 8]                   = ovf;
   end

endmodule

// File: tb/tb_mesh_term_fifo_bank.sv
// tb/tb_mesh_term_fifo_bank.sv - directed scoreboard bench for mesh_term_fifo_bank
module tb_mesh_term_fifo_bank;

   localparam int NTRM  = 16;
   localparam int P     = 40;
   localparam int DEPTH = 4;
   localparam int AF    = 3;
   localparam int CW    = 3;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NTRM-1:0]      push;
   logic [NTRM*P-1:0]    data_in;
   logic [NTRM-1:0]      popin;
   logic                 clr_ovf;
   logic [NTRM*P-1:0]    data_out_i_in;
   logic [NTRM-1:0]      pndng_i_in;
   logic [NTRM-1:0]      full;
   logic [NTRM-1:0]      almost_full;
   logic [NTRM*CW-1:0]   count;
   logic [NTRM*8-1:0]    ovf_cnt;

   int total = 0;
   int bad   = 0;

   logic [P-1:0] sbq [$];
   int           exp_ovf;

   mesh_term_fifo_bank #(
      .ROWS(4), .COLUMS(4), .pckg_sz(P), .fifo_depth(DEPTH), .AF_LEVEL(AF)
   ) dut (
      .clk(clk), .reset(reset), .push(push), .data_in(data_in), .popin(popin),
      .clr_ovf(clr_ovf), .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in),
      .full(full), .almost_full(almost_full), .count(count), .ovf_cnt(ovf_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One cycle on channel ch; the model updates the scoreboard and the outputs are checked.
   task automatic cyc(input int ch, input bit dp, input bit dq, input logic [P-1:0] val,
                      input bit clr, input string tag);
      int n;
      n = sbq.size();
      if (dq && n > 0)
         chk({tag, "_head_at_pop"}, 64'(data_out_i_in[ch*P +: P]), 64'(sbq[0]));
      push = '0; popin = '0; data_in = '0;
      push[ch]  = dp;
      popin[ch] = dq;
      data_in[ch*P +: P] = val;
      clr_ovf = clr;
      step();
      push = '0; popin = '0; clr_ovf = 1'b0; data_in = '0;
      if (dq && n > 0)
         void'(sbq.pop_front());
      if (dp) begin
         if (n < DEPTH || dq) sbq.push_back(val);
         else if (exp_ovf < 255) exp_ovf++;
      end
      if (clr) exp_ovf = 0;
      chk({tag, "_count"}, 64'(count[ch*CW +: CW]), 64'(sbq.size()));
      chk({tag, "_pndng"}, 64'(pndng_i_in[ch]), 64'(sbq.size() > 0));
      chk({tag, "_full"},  64'(full[ch]), 64'(sbq.size() == DEPTH));
      chk({tag, "_afull"}, 64'(almost_full[ch]), 64'(sbq.size() >= AF));
      chk({tag, "_head"},  64'(data_out_i_in[ch*P +: P]),
          (sbq.size() > 0) ? 64'(sbq[0]) : 64'd0);
      chk({tag, "_ovf"},   64'(ovf_cnt[ch*8 +: 8]), 64'(exp_ovf));
   endtask

   task automatic fresh();
      sbq.delete();
      exp_ovf = 0;
   endtask

   initial begin
      reset = 1'b1; push = '0; popin = '0; data_in = '0; clr_ovf = 1'b0;
      step(); step();
      reset = 1'b0;

      for (int c = 0; c < 10; c++) begin
         step();
         chk("idle_pndng", 64'(|pndng_i_in), 64'd0);
         chk("idle_full",  64'(|full), 64'd0);
         chk("idle_afull", 64'(|almost_full), 64'd0);
         chk("idle_count", 64'(|count), 64'd0);
         chk("idle_ovf",   64'(|ovf_cnt), 64'd0);
         chk("idle_data",  64'(|data_out_i_in), 64'd0);
      end

      fresh();
      cyc(5, 1, 0, 40'h0002800001, 0, "ch5_push");
      chk("ch5_only_pndng", 64'(pndng_i_in), 64'h0020);
      chk("ch5_others_count", 64'(count & ~(48'h7 << 15)), 64'd0);

      fresh();
      for (int k = 1; k <= 4; k++) cyc(0, 1, 0, P'(k), 0, "ch0_fill");
      for (int k = 1; k <= 4; k++) cyc(0, 0, 1, '0, 0, "ch0_drain");
      chk("ch0_empty_data", 64'(data_out_i_in[0 +: P]), 64'd0);

      fresh();
      for (int k = 0; k < 4; k++) cyc(15, 1, 0, P'(32'ha0 + k), 0, "ch15_fill");
      for (int k = 0; k < 3; k++) cyc(15, 1, 0, P'(32'hee), 0, "ch15_drop");
      chk("ch15_ovf3", 64'(ovf_cnt[15*8 +: 8]), 64'd3);
      cyc(15, 1, 0, P'(32'hef), 1, "ch15_clr_drop");
      chk("ch15_ovf_cleared", 64'(ovf_cnt[15*8 +: 8]), 64'd0);
      for (int k = 0; k < 4; k++) cyc(15, 0, 1, '0, 0, "ch15_drain");

      fresh();
      for (int k = 10; k <= 13; k++) cyc(2, 1, 0, P'(k), 0, "ch2_fill");
      cyc(2, 1, 1, P'(14), 0, "ch2_fullpp");
      chk("ch2_fullpp_head", 64'(data_out_i_in[2*P +: P]), 64'd11);
      chk("ch2_fullpp_count", 64'(count[2*CW +: CW]), 64'd4);
      for (int k = 0; k < 4; k++) cyc(2, 0, 1, '0, 0, "ch2_drain");

      fresh();
      cyc(7, 0, 1, '0, 0, "ch7_pop_empty");
      cyc(7, 1, 1, P'(9), 0, "ch7_pp_empty");
      chk("ch7_pp_empty_head", 64'(data_out_i_in[7*P +: P]), 64'd9);
      for (int k = 0; k < 3; k++) cyc(7, 1, 0, P'(k + 20), 0, "ch7_fill");
      for (int k = 0; k < 260; k++) cyc(7, 1, 0, P'(32'h55), 0, "ch7_sat");
      chk("ch7_sat_255", 64'(ovf_cnt[7*8 +: 8]), 64'd255);

      fresh();
      cyc(3, 1, 0, P'(31), 0, "ch3_fill");
      cyc(3, 1, 0, P'(32), 0, "ch3_fill");
      push = '0; push[3] = 1'b1; data_in[3*P +: P] = P'(33); popin = '0; popin[3] = 1'b1;
      clr_ovf = 1'b0; reset = 1'b1;
      step();
      reset = 1'b0; push = '0; popin = '0; data_in = '0;
      chk("rst_count", 64'(count[3*CW +: CW]), 64'd0);
      chk("rst_pndng", 64'(pndng_i_in[3]), 64'd0);
      chk("rst_data",  64'(data_out_i_in[3*P +: P]), 64'd0);
      chk("rst_ch7_ovf", 64'(ovf_cnt[7*8 +: 8]), 64'd0);
      step();
      chk("rst_all_pndng", 64'(|pndng_i_in), 64'd0);
      chk("rst_all_count", 64'(|count), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mesh_term_fifo_bank.md
# mesh_term_fifo_bank

Synthesizable bank of per-terminal input FIFOs that feeds packets into the `mesh_gnrtr` router terminals. It generalises the single terminal-side `fifo_in` buffering to all `2*ROWS+2*COLUMS` terminals, with configurable depth and an almost-full threshold. It adds simultaneous push/pop on full, per-channel occupancy, and saturating drop counters. It sits between the host-side packet sources (drivers or upstream logic) and the router's `popin` / `pndng_i_in` / `data_out_i_in` terminal ports.

## Interface
- Clock is `clk`; reset is `reset`, synchronous, active-high.
- NTRM = 2*ROWS+2*COLUMS is a derived localparam. CW = $clog2(fifo_depth+1).
- All per-channel vectors are flattened; channel i occupies slice [i*W +: W].

Parameters:
- `ROWS`, 4, mesh rows.
- `COLUMS`, 4, mesh columns.
- `pckg_sz`, 40, packet width in bits; must be ≥ 18.
- `fifo_depth`, 4, entries per channel; must be ≥ 2.
- `AF_LEVEL`, 3, almost_full asserts when count ≥ AF_LEVEL; must satisfy 1 ≤ AF_LEVEL ≤ fifo_depth.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous active-high reset.
- `push`  in  NTRM  per-channel write strobe.
- `data_in`  in  NTRM*pckg_sz  per-channel write data.
- `popin`  in  NTRM  router pop of head entry.
- `clr_ovf`  in  1  synchronous clear of all drop counters.
- `data_out_i_in`  out  NTRM*pckg_sz  head entry, first-word-fall-through; 0 when empty.
- `pndng_i_in`  out  NTRM  channel non-empty.
- `full`  out  NTRM  count == fifo_depth.
- `almost_full`  out  NTRM  count ≥ AF_LEVEL.
- `count`  out  NTRM*CW  occupancy.
- `ovf_cnt`  out  NTRM*8  saturating count of dropped pushes.

## Operation
- Channels are fully independent; each has a circular buffer with rd_ptr, wr_ptr (0..fifo_depth-1, wrapping to 0 after fifo_depth-1) and count.
- Per-channel cases, evaluated with count before the clock edge:
  - push only, not full: write at wr_ptr; wr_ptr advances; count+1.
  - push only, full: data is dropped. Pointers and count are unchanged. ovf_cnt increments, saturating at 255.
  - popin only, non-empty: rd_ptr advances; count-1.
  - popin only, empty: ignored, with no state change.
  - push and popin, 0 < count < depth: both are performed; count is unchanged.
  - push and popin, full: both are performed (no drop); count stays fifo_depth.
  - push and popin, empty: pop is ignored and push is written; count becomes 1.
- Packet contents are opaque. Header fields (Nxtjp [pckg_sz-1:pckg_sz-8], row, colum, mode, payload) are never modified.
- Drop counters:
  - `clr_ovf` zeroes all ovf_cnt.
  - If clear and a drop coincide, clear wins and the counter becomes 0.
- Reset:
  - Effects: all pointers, counts and ovf_cnt go to 0.
  - Memory contents need not be cleared, because data_out_i_in is forced to 0 when empty.
  - Reset overrides push, popin and clr_ovf in the same cycle.
  - Reset mid-operation discards all queued packets.

## Timing
- Reset values: pndng_i_in=0, full=0, almost_full=0, count=0, ovf_cnt=0, data_out_i_in=0.
- All flags and count are registered-state decodes, with no combinational path from push or popin to any output.
- Push latency:
  - A push at edge N is visible on pndng_i_in and data_out_i_in after edge N (available in cycle N+1).
  - There is no same-cycle bypass.
- Pop:
  - The router samples data_out_i_in while pndng_i_in=1 and asserts popin.
  - The next entry (or 0 if empty) appears after the same edge.
- Back-to-back pops every cycle drain one entry per cycle.
- Sustained push+pop every cycle gives throughput of 1 packet/cycle at any occupancy, including full.

## Test plan
- Reset then idle: all outputs are 0 for 10 cycles. Push 0x0002800001 (row 0, colum 2, mode 1, payload 1) on channel 5 → cycle+1: pndng_i_in[5]=1, data_out_i_in[5]=0x0002800001, count[5]=1; all other channels are unaffected.
- Ordering: push 1,2,3,4 on channel 0 → full[0]=1, almost_full[0]=1 after the 3rd push. Pop 4 times → heads read 1,2,3,4, then pndng_i_in[0]=0 and data = 0.
- Overflow: fill channel 15 (4 entries), push 3 more → ovf_cnt[15]=3, data unchanged. Assert clr_ovf with a drop in the same cycle → ovf_cnt[15]=0.
- Full push+pop: channel 2 full with 10,11,12,13; push 14 with popin in the same cycle → count stays 4, head=11, ovf_cnt=0. Drain reads 11,12,13,14.
- Empty corner: popin on empty channel 7 → no change. Push 9 and popin on empty in the same cycle → count=1, head=9. Saturation: 260 drops on a full channel → ovf_cnt=255.
- Reset mid-operation: channel 3 holds 2 packets; assert reset with push=1 → next cycle count=0, pndng=0, and the pushed data is discarded.
